button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Consumes the clean, debounced level from the debouncer (the debouncer's `salida`) and turns it into discrete one-cycle user events: press, release, long-press and auto-repeat.
- Sits between the debouncer and the VGA control logic, e.g. cursor/sprite movement that repeats while a button is held.
- All outputs are registered; the block runs entirely in the `clk` domain.

Parameters:
- N, 26, width of the internal hold/repeat tick counter.
- LONG_TICKS, 25_000_000, cycles from `press` to `long_press` (0.5 s at 50 MHz); legal range 2..2^N-1.
- REPEAT_TICKS, 5_000_000, cycles between successive `repeat` pulses (and from `long_press` to the first `repeat`); legal range 2..2^N-1.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- boton_db  input  1  debounced button level; 1 = pressed. Already synchronous to `clk`.
- press  output  1  one-cycle pulse on a new press.
- release  output  1  one-cycle pulse when the button is let go.
- long_press  output  1  one-cycle pulse once the hold reaches LONG_TICKS.
- repeat  output  1  one-cycle pulse every REPEAT_TICKS while in the long-hold state.
- held  output  1  level; 1 while the FSM is in B_PRESSED or B_LONG.
- state  output  2  current FSM state encoding, for debug and LEDs.

Behaviour:
- Reset (`rst` = 1 at a clock edge):
  - state = B_IDLE, counter = 0, input sample register = 0.
  - press, release, long_press, repeat, held = 0 from the following cycle.
  - `rst` dominates every other condition.
- Input stage: `boton_db` is registered once into `boton_q`. The FSM acts only on `boton_q`.
- Latency: every event output asserts 2 clock edges after the `boton_db` change that causes it.
- Pulse outputs are high for exactly one cycle. At most one of press / release / long_press / repeat is high in any cycle.
- B_IDLE:
  - `boton_q` = 1 → go to B_PRESSED, counter = 0, press = 1.
- B_PRESSED (counter increments every cycle):
  - `boton_q` = 0 → go to B_IDLE, release = 1.
  - else if counter == LONG_TICKS-1 → go to B_LONG, counter = 0, long_press = 1.
  - Result: long_press is LONG_TICKS cycles after press.
- B_LONG (counter increments every cycle):
  - `boton_q` = 0 → go to B_IDLE, release = 1.
  - else if counter == REPEAT_TICKS-1 → stay in B_LONG, counter = 0, repeat = 1.
  - Result: first repeat is REPEAT_TICKS cycles after long_press, then periodic.
- Simultaneous release and threshold in the same cycle: release wins. No long_press or repeat is emitted, and the counter is cleared.
- Counter is cleared whenever the next state is B_IDLE. It never wraps, because the thresholds are below 2^N.
- Button still high when reset deasserts: `boton_q` samples 1 and a new press is generated. Events interrupted by reset are not replayed.
- One-cycle-high `boton_db`: press, then release exactly 1 cycle later.
- held is registered from the next state, so it rises in the same cycle as press and falls in the same cycle as release.
- Elaboration-time assertion: LONG_TICKS and REPEAT_TICKS are each ≥ 2 and < 2^N.

Decomposition:
- Shared package button_pkg:
  - typedef enum logic [1:0] btn_state_t {B_IDLE = 2'b00, B_PRESSED = 2'b01, B_LONG = 2'b10}; 2'b11 is illegal and recovers to B_IDLE.
  - Default tick constants for 50 MHz.
- One sub-module, btn_timer: N-bit up-counter with synchronous clear and a terminal-compare output against a runtime limit input. It is instantiated once, with the limit muxed by state (LONG_TICKS-1 in B_PRESSED, REPEAT_TICKS-1 in B_LONG).

Test Plan (all scenarios use N=4, LONG_TICKS=8, REPEAT_TICKS=4; cycle 0 is the first edge with `boton_db` = 1):
- Reset:
  - Stimulus: assert `rst` for 3 cycles with `boton_db` = 0, then deassert.
  - Required: all pulse outputs 0, held = 0, state = 2'b00 for all cycles.
- Short press:
  - Stimulus: `boton_db` high for cycles 0..2.
  - Required: press at cycle 2, release at cycle 5, held high for cycles 2..4, no long_press or repeat.
- Long hold:
  - Stimulus: `boton_db` high for cycles 0..19.
  - Required: press at 2, long_press at 10, repeat at 14 and 18, release at 22. held falls at 22 with release, and state returns to 2'b00 at the same time.
- Release at threshold:
  - Stimulus: `boton_db` falls so that `boton_q` = 0 in the same cycle the counter reaches 7.
  - Required: release only, no long_press, state returns to B_IDLE.
- Reset mid-B_LONG:
  - Stimulus: assert `rst` for 1 cycle at cycle 12 while `boton_db` stays high.
  - Required: all outputs 0 in cycle 13, then a new press 2 cycles after `rst` deasserts; no spurious release.
- Single-cycle input:
  - Stimulus: `boton_db` high for cycle 0 only.
  - Required: press at 2, release at 3, held high for cycle 2 only.

Source files
------------

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared types and default timing constants for the button
//               event decoder. The FSM state type encodes B_IDLE, B_PRESSED
//               and B_LONG; 2'b11 is unused and recovers to B_IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef enum logic [1:0] {
        B_IDLE    = 2'b00,
        B_PRESSED = 2'b01,
        B_LONG    = 2'b10
    } btn_state_t;

    // Defaults for a 50 MHz clock: 0.5 s to long-press, 0.1 s repeat period.
    localparam int c_DEFAULT_N            = 26;
    localparam int c_DEFAULT_LONG_TICKS   = 25_000_000;
    localparam int c_DEFAULT_REPEAT_TICKS = 5_000_000;

endpackage : button_pkg
`default_nettype wire

// File: rtl/btn_timer.sv
`default_nettype none
// ============================================================================
// Module      : btn_timer
// Description : N-bit up-counter with synchronous clear and a terminal
//               compare against a runtime limit.
// Ports       : clk, rst      - clock / synchronous active-high reset
//               clear         - load zero on the next edge (else increment)
//               limit[N-1:0]  - terminal value to compare against
//               at_limit      - combinational: count == limit
// Revision    : 1.0 - initial release
// ============================================================================
module btn_timer #(
    parameter int N = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [N-1:0] limit,
    output logic         at_limit
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = clear ? '0 : count_q + N'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit = (count_q == limit);

endmodule : btn_timer
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : button_event_decoder
// Description : Turns a debounced button level into one-cycle press,
//               release, long-press and auto-repeat events.
// Ports       : clk, rst       - clock / synchronous active-high reset
//               boton_db       - debounced button level, 1 = pressed
//               press          - pulse on a new press
//               release_pulse  - pulse when the button is let go
//               long_press     - pulse once the hold reaches LONG_TICKS
//               repeat_pulse   - pulse every REPEAT_TICKS while long-held
//               held           - level, 1 while pressed or long-held
//               state[1:0]     - current FSM state (debug / LEDs)
//               The release and repeat events carry a _pulse suffix because
//               "release" and "repeat" are reserved words in SystemVerilog.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_decoder
    import button_pkg::*;
#(
    parameter int N            = c_DEFAULT_N,
    parameter int LONG_TICKS   = c_DEFAULT_LONG_TICKS,
    parameter int REPEAT_TICKS = c_DEFAULT_REPEAT_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       boton_db,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [1:0] state
);

    // Thresholds must fit the counter and leave at least one idle count.
    if (LONG_TICKS < 2 || 64'(LONG_TICKS) >= (64'd1 << N)) begin : g_bad_long_ticks
        $error("LONG_TICKS must be in 2..2^N-1");
    end
    if (REPEAT_TICKS < 2 || 64'(REPEAT_TICKS) >= (64'd1 << N)) begin : g_bad_repeat_ticks
        $error("REPEAT_TICKS must be in 2..2^N-1");
    end

    localparam logic [N-1:0] LONG_LIMIT   = N'(LONG_TICKS - 1);
    localparam logic [N-1:0] REPEAT_LIMIT = N'(REPEAT_TICKS - 1);

    btn_state_t   state_q, state_d;
    logic         boton_q, boton_d;
    logic         press_q, press_d;
    logic         release_q, release_d;
    logic         long_q, long_d;
    logic         repeat_q, repeat_d;
    logic         held_q, held_d;
    logic         cnt_clear;
    logic [N-1:0] cnt_limit;
    logic         cnt_at_limit;

    // Limit mux kept apart from the FSM block so the timer compare does not
    // form a combinational feedback path through a single process.
    always_comb begin
        case (state_q)
            B_PRESSED: cnt_limit = LONG_LIMIT;
            B_LONG:    cnt_limit = REPEAT_LIMIT;
            default:   cnt_limit = '0;
        endcase
    end

    btn_timer #(
        .N (N)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .limit    (cnt_limit),
        .at_limit (cnt_at_limit)
    );

    always_comb begin
        boton_d   = boton_db;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            B_IDLE: begin
                if (boton_q) begin
                    state_d = B_PRESSED;
                    press_d = 1'b1;
                end
            end
            B_PRESSED: begin
                // Release is checked first so it wins over the threshold.
                if (!boton_q) begin
                    state_d   = B_IDLE;
                    release_d = 1'b1;
                end else if (cnt_at_limit) begin
                    state_d = B_LONG;
                    long_d  = 1'b1;
                end
            end
            B_LONG: begin
                if (!boton_q) begin
                    state_d   = B_IDLE;
                    release_d = 1'b1;
                end else if (cnt_at_limit) begin
                    repeat_d = 1'b1;
                end
            end
            default: begin
                state_d = B_IDLE;
            end
        endcase

        held_d    = (state_d == B_PRESSED) || (state_d == B_LONG);
        // Restart the count at every period boundary and hold it at zero
        // while idle, so it never wraps.
        cnt_clear = (state_d == B_IDLE) || press_d || long_d || repeat_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= B_IDLE;
            boton_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            boton_q   <= boton_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign state         = state_q;

endmodule : button_event_decoder
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_decoder
// Description : Self-checking bench for button_event_decoder (N=4,
//               LONG_TICKS=8, REPEAT_TICKS=4). A time-since-press model
//               predicts every output each cycle; directed scenarios pin
//               event timing to hand-computed cycle numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

    localparam int N            = 4;
    localparam int LONG_TICKS   = 8;
    localparam int REPEAT_TICKS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       boton_db = 1'b0;
    logic       press, release_pulse, long_press, repeat_pulse, held;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .N            (N),
        .LONG_TICKS   (LONG_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .boton_db      (boton_db),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held),
        .state         (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: m_q is the one-edge-delayed input, m_hold counts
    // cycles elapsed since the press event. Events follow from arithmetic
    // on m_hold: long-press at LONG_TICKS, repeats every REPEAT_TICKS after.
    bit         m_q, m_pressed;
    int         m_hold;
    bit         e_press, e_rel, e_long, e_rep, e_held;
    logic [1:0] e_state;

    always @(posedge clk) begin
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
        if (rst) begin
            m_q = 1'b0; m_pressed = 1'b0; m_hold = 0;
        end else begin
            if (!m_pressed) begin
                if (m_q) begin
                    e_press = 1'b1; m_pressed = 1'b1; m_hold = 0;
                end
            end else if (!m_q) begin
                e_rel = 1'b1; m_pressed = 1'b0;
            end else begin
                m_hold++;
                if (m_hold == LONG_TICKS)
                    e_long = 1'b1;
                else if (m_hold > LONG_TICKS && (m_hold - LONG_TICKS) % REPEAT_TICKS == 0)
                    e_rep = 1'b1;
            end
            m_q = boton_db;
        end
        e_held  = m_pressed;
        e_state = !m_pressed ? 2'd0 : (m_hold >= LONG_TICKS ? 2'd2 : 2'd1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("press",      press,         e_press);
            check("release",    release_pulse, e_rel);
            check("long_press", long_press,    e_long);
            check("repeat",     repeat_pulse,  e_rep);
            check("held",       held,          e_held);
            check("state",      state,         e_state);
        end
    end

    // Raises boton_db before edge 0, drops it before edge H, and records the
    // cycle (j = sample just before edge j) of each event over L cycles.
    task automatic run_press(input int H, input int L,
                             output int p, output int r, output int lp,
                             output int nrep, output int rep0, output int rep1,
                             output int nheld, output int st_rel);
        p = -1; r = -1; lp = -1; nrep = 0; rep0 = -1; rep1 = -1; nheld = 0; st_rel = -1;
        @(negedge clk);
        boton_db = 1'b1;
        for (int j = 1; j <= L; j++) begin
            @(negedge clk);
            if (press && p < 0) p = j;
            if (release_pulse && r < 0) begin
                r = j;
                st_rel = int'(state);
            end
            if (long_press && lp < 0) lp = j;
            if (repeat_pulse) begin
                if (nrep == 0) rep0 = j;
                else if (nrep == 1) rep1 = j;
                nrep++;
            end
            if (held) nheld++;
            if (j == H) boton_db = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            boton_db = 1'b0;
            rst = 1'b0;
        end
    endtask

    int p, r, lp, nrep, rep0, rep1, nheld, st_rel;
    int rp, nrel;
    bit lvl;
    int len;

    initial begin
        // Reset held for 3 cycles with the button released.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_pulses", {press, release_pulse, long_press, repeat_pulse}, 0);
            check("rst_held",   held,  0);
            check("rst_state",  state, 0);
        end
        chk_en = 1'b1;
        idle(4);

        // Short press: high for cycles 0..2.
        run_press(3, 10, p, r, lp, nrep, rep0, rep1, nheld, st_rel);
        check("short_press_cyc",   p, 2);
        check("short_release_cyc", r, 5);
        check("short_held_cycles", nheld, 3);
        check("short_no_long",     lp, -1);
        check("short_no_repeat",   nrep, 0);
        idle(3);

        // Long hold: high for cycles 0..19.
        run_press(20, 26, p, r, lp, nrep, rep0, rep1, nheld, st_rel);
        check("long_press_cyc",  p, 2);
        check("long_long_cyc",   lp, 10);
        check("long_rep0_cyc",   rep0, 14);
        check("long_rep1_cyc",   rep1, 18);
        check("long_nrep",       nrep, 2);
        check("long_release",    r, 22);
        check("long_state_rel",  st_rel, 0);
        check("long_held_cycles", nheld, 20);
        idle(3);

        // Release lands on the same cycle the count reaches LONG_TICKS-1.
        run_press(8, 14, p, r, lp, nrep, rep0, rep1, nheld, st_rel);
        check("thr_release_cyc", r, 10);
        check("thr_no_long",     lp, -1);
        check("thr_state_rel",   st_rel, 0);
        idle(3);

        // Single-cycle input.
        run_press(1, 6, p, r, lp, nrep, rep0, rep1, nheld, st_rel);
        check("single_press_cyc",   p, 2);
        check("single_release_cyc", r, 3);
        check("single_held_cycles", nheld, 1);
        idle(3);

        // Reset for one cycle at edge 12 while the button stays held.
        rp = -1; nrel = 0;
        @(negedge clk);
        boton_db = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (j == 13) begin
                check("rstmid_pulses", {press, release_pulse, long_press, repeat_pulse}, 0);
                check("rstmid_held",   held,  0);
                check("rstmid_state",  state, 0);
            end
            if (j > 13 && press && rp < 0) rp = j;
            if (j >= 13 && release_pulse) nrel++;
            rst = (j == 12);
        end
        check("rstmid_new_press", rp, 15);
        check("rstmid_no_release", nrel, 0);
        idle(4);

        // Randomized runs of held/released levels with occasional resets.
        for (int k = 0; k < 150; k++) begin
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 30));
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                boton_db = lvl;
                rst = ($urandom_range(0, 99) == 0);
            end
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_button_event_decoder
`default_nettype wire
